// File: rtl/irq_prio_ctrl8_pkg.sv
// irq_prio_ctrl8_pkg: shared sizes and FSM state encoding for the interrupt controller
package irq_prio_ctrl8_pkg;
    localparam int NUM_SRC = 8;
    localparam int VEC_W = 3;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;
endpackage

// File: rtl/irq_prio_ctrl8_if.sv
// irq_prio_ctrl8_if: request, mask, handshake and status bundle between source side and controller
interface irq_prio_ctrl8_if import irq_prio_ctrl8_pkg::*; ();
    logic [NUM_SRC-1:0] req_in;
    logic               mask_wr;
    logic [NUM_SRC-1:0] mask_in;
    logic               irq;
    logic               irq_ack;
    logic [VEC_W-1:0]   vec;
    logic               vec_valid;
    logic               eoi;
    logic [NUM_SRC-1:0] pending;
    logic               in_service;
    modport master (
        output req_in, mask_wr, mask_in, irq_ack, eoi,
        input  irq, vec, vec_valid, pending, in_service
    );
    modport slave (
        input  req_in, mask_wr, mask_in, irq_ack, eoi,
        output irq, vec, vec_valid, pending, in_service
    );
endinterface

// File: rtl/irq_prio_ctrl8_pick8.sv
// irq_prio_ctrl8_pick8: combinational highest-bit-first picker over the eligible sources
module irq_prio_pick8 import irq_prio_ctrl8_pkg::*; (
    input  logic [NUM_SRC-1:0] eligible,
    output logic [VEC_W-1:0]   sel,
    output logic               any
);
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++) if (eligible[i]) sel = VEC_W'(i);
    end
    assign any = |eligible;
endmodule

// File: rtl/irq_prio_ctrl8.sv
// irq_prio_ctrl8: edge-capturing masked priority interrupt controller with irq/ack/eoi handshake; IRQ_SYNC_EN adds a 2-flop input synchronizer
module irq_prio_ctrl8 import irq_prio_ctrl8_pkg::*; #(
    parameter logic [NUM_SRC-1:0] RESET_MASK = 8'h00
) (
    input logic clk,
    input logic rst_n,
    irq_prio_ctrl8_if.slave bus
);
    logic [NUM_SRC-1:0] req_s, req_q, pending_q, pending_d, mask_q, mask_d;
    logic [NUM_SRC-1:0] rise, eligible, clr;
    logic [VEC_W-1:0]   sel, vec_q, vec_d;
    logic               any, irq_q, irq_d, vec_valid_q, vec_valid_d, in_service_q, in_service_d;
    state_e             state_q, state_d;
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.req_in;
            sync2_q <= sync1_q;
        end
    end
    assign req_s = sync2_q;
`else
    assign req_s = bus.req_in;
`endif
    irq_prio_pick8 u_pick (.eligible(eligible), .sel(sel), .any(any));
    always_comb begin
        rise = req_s & ~req_q;
        eligible = pending_q & ~mask_q;
        mask_d = bus.mask_wr ? bus.mask_in : mask_q;
        state_d = state_q;
        irq_d = irq_q;
        vec_d = vec_q;
        vec_valid_d = vec_valid_q;
        in_service_d = in_service_q;
        clr = '0;
        case (state_q)
            IDLE: if (any) begin
                state_d = REQ;
                irq_d = 1'b1;
                vec_d = sel;
            end
            REQ: if (!any) begin
                state_d = IDLE;
                irq_d = 1'b0;
            end else begin
                vec_d = sel;
                if (bus.irq_ack) begin
                    state_d = SERVICE;
                    irq_d = 1'b0;
                    vec_valid_d = 1'b1;
                    in_service_d = 1'b1;
                    clr = NUM_SRC'(1) << sel;
                end
            end
            SERVICE: if (bus.eoi) begin
                state_d = IDLE;
                vec_valid_d = 1'b0;
                in_service_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // a new edge on the bit being served survives the clear
        pending_d = (pending_q & ~clr) | rise;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            pending_q <= '0;
            mask_q <= RESET_MASK;
            state_q <= IDLE;
            irq_q <= 1'b0;
            vec_q <= '0;
            vec_valid_q <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            req_q <= req_s;
            pending_q <= pending_d;
            mask_q <= mask_d;
            state_q <= state_d;
            irq_q <= irq_d;
            vec_q <= vec_d;
            vec_valid_q <= vec_valid_d;
            in_service_q <= in_service_d;
        end
    end
    assign bus.irq = irq_q;
    assign bus.vec = vec_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.pending = pending_q;
    assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_irq_prio_ctrl8.sv
// tb_irq_prio_ctrl8: directed scenarios for irq_prio_ctrl8 with hand-computed expectations
module tb_irq_prio_ctrl8;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    irq_prio_ctrl8_if bus ();
    irq_prio_ctrl8 #(.RESET_MASK(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive_req(input logic [7:0] v);
        bus.req_in = v;
        tick();
        bus.req_in = '0;
        repeat (LAT - 2) tick();
    endtask
    task automatic do_ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask
    task automatic do_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask
    task automatic test_reset();
        bus.req_in = '0; bus.mask_wr = 1'b0; bus.mask_in = '0; bus.irq_ack = 1'b0; bus.eoi = 1'b0;
        rst_n = 1'b0;
        #12;
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0h exp=0", bus.irq); end
        total++; if (bus.vec !== 3'd0) begin bad++; $display("FAIL reset_vec got=%0h exp=0", bus.vec); end
        total++; if (bus.vec_valid !== 1'b0) begin bad++; $display("FAIL reset_vec_valid got=%0h exp=0", bus.vec_valid); end
        total++; if (bus.in_service !== 1'b0) begin bad++; $display("FAIL reset_in_service got=%0h exp=0", bus.in_service); end
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL reset_pending got=%0h exp=0", bus.pending); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask
    task automatic test_basic();
        drive_req(8'h08);
        total++; if (bus.pending !== 8'h08) begin bad++; $display("FAIL basic_pending got=%0h exp=08", bus.pending); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL basic_irq_early got=%0h exp=0", bus.irq); end
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%0h exp=1", bus.irq); end
        total++; if (bus.vec !== 3'd3) begin bad++; $display("FAIL basic_vec got=%0h exp=3", bus.vec); end
        do_ack();
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL basic_ack_pending got=%0h exp=0", bus.pending); end
        total++; if (bus.vec_valid !== 1'b1) begin bad++; $display("FAIL basic_ack_valid got=%0h exp=1", bus.vec_valid); end
        total++; if (bus.in_service !== 1'b1) begin bad++; $display("FAIL basic_ack_insvc got=%0h exp=1", bus.in_service); end
        total++; if (bus.vec !== 3'd3) begin bad++; $display("FAIL basic_ack_vec got=%0h exp=3", bus.vec); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL basic_ack_irq got=%0h exp=0", bus.irq); end
        do_ack();
        total++; if (bus.vec_valid !== 1'b1) begin bad++; $display("FAIL basic_ack_ignored got=%0h exp=1", bus.vec_valid); end
        do_eoi();
        total++; if (bus.vec_valid !== 1'b0) begin bad++; $display("FAIL basic_eoi_valid got=%0h exp=0", bus.vec_valid); end
        total++; if (bus.in_service !== 1'b0) begin bad++; $display("FAIL basic_eoi_insvc got=%0h exp=0", bus.in_service); end
        tick();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL basic_idle_irq got=%0h exp=0", bus.irq); end
    endtask
    task automatic test_simultaneous();
        drive_req(8'h05);
        tick();
        total++; if (bus.vec !== 3'd2) begin bad++; $display("FAIL simul_vec_hi got=%0h exp=2", bus.vec); end
        do_ack();
        total++; if (bus.pending !== 8'h01) begin bad++; $display("FAIL simul_pending got=%0h exp=01", bus.pending); end
        do_eoi();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL simul_no_bypass got=%0h exp=0", bus.irq); end
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL simul_irq2 got=%0h exp=1", bus.irq); end
        total++; if (bus.vec !== 3'd0) begin bad++; $display("FAIL simul_vec_lo got=%0h exp=0", bus.vec); end
        do_ack();
        do_eoi();
        tick();
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL simul_final_pending got=%0h exp=0", bus.pending); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL simul_final_irq got=%0h exp=0", bus.irq); end
    endtask
    task automatic test_preempt();
        drive_req(8'h02);
        tick();
        total++; if (bus.vec !== 3'd1) begin bad++; $display("FAIL preempt_vec1 got=%0h exp=1", bus.vec); end
        drive_req(8'h40);
        tick();
        total++; if (bus.vec !== 3'd6) begin bad++; $display("FAIL preempt_vec6 got=%0h exp=6", bus.vec); end
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL preempt_irq got=%0h exp=1", bus.irq); end
        do_ack();
        total++; if (bus.vec !== 3'd6) begin bad++; $display("FAIL preempt_served got=%0h exp=6", bus.vec); end
        total++; if (bus.pending !== 8'h02) begin bad++; $display("FAIL preempt_pending got=%0h exp=02", bus.pending); end
        do_eoi();
        tick();
        total++; if (bus.vec !== 3'd1) begin bad++; $display("FAIL preempt_next got=%0h exp=1", bus.vec); end
        do_ack();
        do_eoi();
        tick();
    endtask
    task automatic test_mask();
        drive_req(8'h10);
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL mask_pre_irq got=%0h exp=1", bus.irq); end
        bus.mask_wr = 1'b1; bus.mask_in = 8'h10;
        tick();
        bus.mask_wr = 1'b0;
        tick();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mask_irq_drop got=%0h exp=0", bus.irq); end
        total++; if (bus.pending !== 8'h10) begin bad++; $display("FAIL mask_pending got=%0h exp=10", bus.pending); end
        tick();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mask_irq_stays got=%0h exp=0", bus.irq); end
        bus.mask_wr = 1'b1; bus.mask_in = 8'h00;
        tick();
        bus.mask_wr = 1'b0;
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL unmask_irq got=%0h exp=1", bus.irq); end
        total++; if (bus.vec !== 3'd4) begin bad++; $display("FAIL unmask_vec got=%0h exp=4", bus.vec); end
        do_ack();
        do_eoi();
        tick();
    endtask
    task automatic test_set_wins();
        drive_req(8'h20);
        tick();
        total++; if (bus.vec !== 3'd5) begin bad++; $display("FAIL setwin_vec got=%0h exp=5", bus.vec); end
        bus.req_in = 8'h20;
        repeat (LAT - 2) begin
            tick();
            bus.req_in = '0;
        end
        do_ack();
        bus.req_in = '0;
        total++; if (bus.pending !== 8'h20) begin bad++; $display("FAIL setwin_pending got=%0h exp=20", bus.pending); end
        total++; if (bus.vec_valid !== 1'b1) begin bad++; $display("FAIL setwin_valid got=%0h exp=1", bus.vec_valid); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL setwin_no_nest got=%0h exp=0", bus.irq); end
        do_eoi();
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL setwin_reserve_irq got=%0h exp=1", bus.irq); end
        total++; if (bus.vec !== 3'd5) begin bad++; $display("FAIL setwin_reserve_vec got=%0h exp=5", bus.vec); end
        do_ack();
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL setwin_final got=%0h exp=0", bus.pending); end
        do_eoi();
        tick();
    endtask
    task automatic test_reset_mid();
        drive_req(8'h01);
        tick();
        do_ack();
        bus.mask_wr = 1'b1; bus.mask_in = 8'hff;
        tick();
        bus.mask_wr = 1'b0;
        drive_req(8'h02);
        total++; if (bus.in_service !== 1'b1) begin bad++; $display("FAIL mid_pre_insvc got=%0h exp=1", bus.in_service); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.vec_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0h exp=0", bus.vec_valid); end
        total++; if (bus.in_service !== 1'b0) begin bad++; $display("FAIL mid_insvc got=%0h exp=0", bus.in_service); end
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL mid_pending got=%0h exp=0", bus.pending); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%0h exp=0", bus.irq); end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mid_lost got=%0h exp=0", bus.irq); end
        drive_req(8'h01);
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL mid_mask_restored got=%0h exp=1", bus.irq); end
        total++; if (bus.vec !== 3'd0) begin bad++; $display("FAIL mid_vec got=%0h exp=0", bus.vec); end
        do_ack();
        do_eoi();
        tick();
    endtask
    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_preempt();
        test_mask();
        test_set_wins();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
